cpu_bus_responder: RTL and testbench

- Slave end of the external CPU parallel bus, sitting between the CPU pins and the four BRAM ports (controller, mod, normal, stm).
- Registers bus pins and decodes each CS/WE access into exactly one single-cycle BRAM write strobe with latched address, data and select.
- Serves CPU reads through a fixed-latency BRAM read sequence.
- Maintains the mod and stm page-offset registers, so wide memories are reachable through the 14-bit window.

---
 rtl/cpu_bus_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: slave end of the external CPU parallel bus, feeding four BRAM ports.
// Latency: pin to write strobe 2 cycles; pin to read data/OE READ_LATENCY+2 cycles.
// Backpressure: none; the CPU paces accesses, a new access is taken only from IDLE.
//
// Optional read path: define CPU_BUS_READBACK_EN to build RD_WAIT/RD_DRIVE and drive
// CPU_DATA_OUT/CPU_DATA_OE/BRAM_RD_SEL. Without it, RD is ignored and those outputs are 0.
//
// Ports:
//   BUS_CLK, RST_N           - bus clock (CKIO), async active-low reset
//   CPU_CS1_N/WE0_N/RD_N     - active-low bus strobes
//   CPU_ADDR[16:0]           - [16:15] BRAM select, [14:1] word address, [0] unused
//   CPU_DATA_IN/OUT/OE       - pin data in, read data out, pin driver enable
//   BRAM_WE[3:0]             - one-hot write strobe (0 ctl, 1 mod, 2 normal, 3 stm)
//   BRAM_ADDR/DIN/RD_SEL     - latched word address, write data, read mux select
//   BRAM_DOUT                - read data, valid READ_LATENCY cycles after address
//   MOD_PAGE, STM_PAGE       - page-offset registers written via the controller window
module cpu_bus_responder #(
    parameter int                    ADDR_WIDTH      = 14,
    parameter int                    DATA_WIDTH      = 16,
    parameter int                    READ_LATENCY    = 2,
    parameter logic [ADDR_WIDTH-1:0] MOD_OFFSET_ADDR = 14'h0020,
    parameter logic [ADDR_WIDTH-1:0] STM_OFFSET_ADDR = 14'h0021
) (
    input  logic                  BUS_CLK,
    input  logic                  RST_N,
    input  logic                  CPU_CS1_N,
    input  logic                  CPU_WE0_N,
    input  logic                  CPU_RD_N,
    input  logic [ADDR_WIDTH+2:0] CPU_ADDR,
    input  logic [DATA_WIDTH-1:0] CPU_DATA_IN,
    output logic [DATA_WIDTH-1:0] CPU_DATA_OUT,
    output logic                  CPU_DATA_OE,
    output logic [3:0]            BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_DIN,
    output logic [1:0]            BRAM_RD_SEL,
    input  logic [DATA_WIDTH-1:0] BRAM_DOUT,
    output logic                  MOD_PAGE,
    output logic [4:0]            STM_PAGE
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_HOLD  = 2'd1
`ifdef CPU_BUS_READBACK_EN
        ,
        RD_WAIT  = 2'd2,
        RD_DRIVE = 2'd3
`endif
    } state_t;

    // Input stage: one register on every pin, strobes kept active-low as on the pins.
    logic                  cs_n_q, cs_n_d;
    logic                  we_n_q, we_n_d;
    logic [1:0]            sel_in_q, sel_in_d;
    logic [ADDR_WIDTH-1:0] addr_in_q, addr_in_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;

    state_t                state_q, state_d;
    logic [3:0]            bram_we_q, bram_we_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;
    logic                  mod_page_q, mod_page_d;
    logic [4:0]            stm_page_q, stm_page_d;

    logic                  cs_act;
    logic                  we_act;
    logic                  unused_pins;

`ifdef CPU_BUS_READBACK_EN
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    logic                  rd_n_q, rd_n_d;
    logic                  rd_act;
    logic [1:0]            rd_sel_q, rd_sel_d;
    logic [1:0]            lat_cnt_q, lat_cnt_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_oe_q, data_oe_d;

    assign rd_act      = ~rd_n_q;
    assign unused_pins = CPU_ADDR[0];
`else
    assign unused_pins = ^{CPU_ADDR[0], CPU_RD_N, BRAM_DOUT};
`endif

    assign cs_act = ~cs_n_q;
    assign we_act = ~we_n_q;

    always_comb begin
        cs_n_d    = CPU_CS1_N;
        we_n_d    = CPU_WE0_N;
        sel_in_d  = CPU_ADDR[ADDR_WIDTH+2:ADDR_WIDTH+1];
        addr_in_d = CPU_ADDR[ADDR_WIDTH:1];
        data_in_d = CPU_DATA_IN;
`ifdef CPU_BUS_READBACK_EN
        rd_n_d    = CPU_RD_N;
`endif
    end

    always_comb begin
        state_d     = state_q;
        bram_we_d   = 4'b0000;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        mod_page_d  = mod_page_q;
        stm_page_d  = stm_page_q;
`ifdef CPU_BUS_READBACK_EN
        rd_sel_d    = rd_sel_q;
        lat_cnt_d   = lat_cnt_q;
        data_out_d  = data_out_q;
        data_oe_d   = data_oe_q;
`endif
        case (state_q)
            IDLE: begin
                // Write takes priority over a simultaneous read.
                if (cs_act && we_act) begin
                    bram_addr_d = addr_in_q;
                    bram_din_d  = data_in_q;
                    bram_we_d   = 4'b0001 << sel_in_q;
                    if (sel_in_q == 2'd0 && addr_in_q == MOD_OFFSET_ADDR) begin
                        mod_page_d = data_in_q[0];
                    end
                    if (sel_in_q == 2'd0 && addr_in_q == STM_OFFSET_ADDR) begin
                        stm_page_d = data_in_q[4:0];
                    end
                    state_d = WR_HOLD;
                end
`ifdef CPU_BUS_READBACK_EN
                else if (cs_act && rd_act) begin
                    bram_addr_d = addr_in_q;
                    rd_sel_d    = sel_in_q;
                    lat_cnt_d   = 2'd0;
                    state_d     = RD_WAIT;
                end
`endif
            end
            // Park here until the CPU lets go so a long WE gives a single strobe.
            WR_HOLD: begin
                if (!we_act || !cs_act) begin
                    state_d = IDLE;
                end
            end
`ifdef CPU_BUS_READBACK_EN
            RD_WAIT: begin
                // Abort is checked first: a CS release wins over a same-cycle capture.
                if (!cs_act) begin
                    state_d = IDLE;
                end else if (lat_cnt_q == LAT_LAST) begin
                    data_out_d = BRAM_DOUT;
                    data_oe_d  = 1'b1;
                    state_d    = RD_DRIVE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            RD_DRIVE: begin
                // Data stays on the output register after OE drops.
                if (!rd_act || !cs_act) begin
                    data_oe_d = 1'b0;
                    state_d   = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            cs_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            sel_in_q    <= '0;
            addr_in_q   <= '0;
            data_in_q   <= '0;
            state_q     <= IDLE;
            bram_we_q   <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            mod_page_q  <= 1'b0;
            stm_page_q  <= '0;
`ifdef CPU_BUS_READBACK_EN
            rd_n_q      <= 1'b1;
            rd_sel_q    <= '0;
            lat_cnt_q   <= '0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
`endif
        end else begin
            cs_n_q      <= cs_n_d;
            we_n_q      <= we_n_d;
            sel_in_q    <= sel_in_d;
            addr_in_q   <= addr_in_d;
            data_in_q   <= data_in_d;
            state_q     <= state_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            mod_page_q  <= mod_page_d;
            stm_page_q  <= stm_page_d;
`ifdef CPU_BUS_READBACK_EN
            rd_n_q      <= rd_n_d;
            rd_sel_q    <= rd_sel_d;
            lat_cnt_q   <= lat_cnt_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
`endif
        end
    end

    assign BRAM_WE   = bram_we_q;
    assign BRAM_ADDR = bram_addr_q;
    assign BRAM_DIN  = bram_din_q;
    assign MOD_PAGE  = mod_page_q;
    assign STM_PAGE  = stm_page_q;

`ifdef CPU_BUS_READBACK_EN
    assign BRAM_RD_SEL  = rd_sel_q;
    assign CPU_DATA_OUT = data_out_q;
    assign CPU_DATA_OE  = data_oe_q;
`else
    assign BRAM_RD_SEL  = 2'd0;
    assign CPU_DATA_OUT = '0;
    assign CPU_DATA_OE  = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed self-checking bench for cpu_bus_responder.
// Pins are driven and outputs sampled 1 ns after each rising edge.
// The BRAM model answers 0x1234 for select 3 / address 0x0100, 0xDEAD elsewhere.
module tb_cpu_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n, we_n, rd_n;
    logic [16:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        cpu_oe;
    logic [3:0]  bram_we;
    logic [13:0] bram_addr;
    logic [15:0] bram_din;
    logic [1:0]  rd_sel;
    logic [15:0] bram_dout = 16'h0000;
    logic        mod_page;
    logic [4:0]  stm_page;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bram_dout <= (rd_sel == 2'd3 && bram_addr == 14'h0100) ? 16'h1234 : 16'hDEAD;
    end

    cpu_bus_responder dut (
        .BUS_CLK      (clk),
        .RST_N        (rst_n),
        .CPU_CS1_N    (cs_n),
        .CPU_WE0_N    (we_n),
        .CPU_RD_N     (rd_n),
        .CPU_ADDR     (cpu_addr),
        .CPU_DATA_IN  (cpu_din),
        .CPU_DATA_OUT (cpu_dout),
        .CPU_DATA_OE  (cpu_oe),
        .BRAM_WE      (bram_we),
        .BRAM_ADDR    (bram_addr),
        .BRAM_DIN     (bram_din),
        .BRAM_RD_SEL  (rd_sel),
        .BRAM_DOUT    (bram_dout),
        .MOD_PAGE     (mod_page),
        .STM_PAGE     (stm_page)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pins(input logic cs, input logic we, input logic rd,
                            input logic [1:0] sel, input logic [13:0] a, input logic [15:0] d);
        cs_n     = cs;
        we_n     = we;
        rd_n     = rd;
        cpu_addr = {sel, a, 1'b0};
        cpu_din  = d;
    endtask

    // Holds CS/WE (and optionally RD) low for n_low sampled edges, then releases and
    // watches a few more cycles, recording every strobe and any OE activity.
    task automatic drive_write(input logic [1:0] sel, input logic [13:0] a, input logic [15:0] d,
                               input int n_low, input logic with_rd,
                               output int n_str, output logic [3:0] we_seen, output int first_at,
                               output logic [13:0] addr_seen, output logic [15:0] din_seen,
                               output logic oe_seen);
        set_pins(1'b0, 1'b0, with_rd ? 1'b0 : 1'b1, sel, a, d);
        n_str = 0; we_seen = 4'd0; first_at = -1; addr_seen = 14'd0; din_seen = 16'd0; oe_seen = 1'b0;
        for (int i = 1; i <= n_low + 4; i++) begin
            tick();
            if (bram_we != 4'd0) begin
                n_str++;
                we_seen   = bram_we;
                addr_seen = bram_addr;
                din_seen  = bram_din;
                if (first_at < 0) first_at = i;
            end
            if (cpu_oe) oe_seen = 1'b1;
            if (i == n_low) begin
                cs_n = 1'b1; we_n = 1'b1; rd_n = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_pins(1'b1, 1'b1, 1'b1, 2'd0, 14'd0, 16'd0);
        tick();
        checks++; if (bram_we !== 4'd0)    begin errors++; $display("FAIL reset_we: got %b expected 0000", bram_we); end
        checks++; if (bram_addr !== 14'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0000", bram_addr); end
        checks++; if (bram_din !== 16'd0)  begin errors++; $display("FAIL reset_din: got %h expected 0000", bram_din); end
        checks++; if (mod_page !== 1'b0)   begin errors++; $display("FAIL reset_mod: got %b expected 0", mod_page); end
        checks++; if (stm_page !== 5'd0)   begin errors++; $display("FAIL reset_stm: got %h expected 00", stm_page); end
        checks++; if (cpu_oe !== 1'b0)     begin errors++; $display("FAIL reset_oe: got %b expected 0", cpu_oe); end
        checks++; if (cpu_dout !== 16'd0)  begin errors++; $display("FAIL reset_dout: got %h expected 0000", cpu_dout); end
        checks++; if (rd_sel !== 2'd0)     begin errors++; $display("FAIL reset_rdsel: got %h expected 0", rd_sel); end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (bram_we !== 4'd0) begin errors++; $display("FAIL post_reset_we: got %b expected 0000", bram_we); end
    endtask

    task automatic test_write();
        int n; logic [3:0] w; int f; logic [13:0] a; logic [15:0] d; logic o;
        drive_write(2'd2, 14'h0005, 16'hA5A5, 2, 1'b0, n, w, f, a, d, o);
        checks++; if (n !== 1)          begin errors++; $display("FAIL write_count: got %0d expected 1", n); end
        checks++; if (w !== 4'b0100)    begin errors++; $display("FAIL write_we: got %b expected 0100", w); end
        checks++; if (f !== 2)          begin errors++; $display("FAIL write_latency: got %0d expected 2", f); end
        checks++; if (a !== 14'h0005)   begin errors++; $display("FAIL write_addr: got %h expected 0005", a); end
        checks++; if (d !== 16'hA5A5)   begin errors++; $display("FAIL write_din: got %h expected a5a5", d); end
        checks++; if (bram_addr !== 14'h0005) begin errors++; $display("FAIL write_addr_hold: got %h expected 0005", bram_addr); end
        checks++; if (mod_page !== 1'b0 || stm_page !== 5'd0) begin errors++; $display("FAIL write_pages: got %b/%h expected 0/00", mod_page, stm_page); end
    endtask

    task automatic test_page_regs();
        int n; logic [3:0] w; int f; logic [13:0] a; logic [15:0] d; logic o;
        drive_write(2'd0, 14'h0021, 16'h0013, 2, 1'b0, n, w, f, a, d, o);
        checks++; if (w !== 4'b0001)  begin errors++; $display("FAIL stm_we: got %b expected 0001", w); end
        checks++; if (stm_page !== 5'h13) begin errors++; $display("FAIL stm_page: got %h expected 13", stm_page); end
        checks++; if (mod_page !== 1'b0)  begin errors++; $display("FAIL stm_mod: got %b expected 0", mod_page); end
        drive_write(2'd0, 14'h0020, 16'h0001, 2, 1'b0, n, w, f, a, d, o);
        checks++; if (w !== 4'b0001)  begin errors++; $display("FAIL mod_we: got %b expected 0001", w); end
        checks++; if (mod_page !== 1'b1)  begin errors++; $display("FAIL mod_page: got %b expected 1", mod_page); end
        checks++; if (stm_page !== 5'h13) begin errors++; $display("FAIL mod_stm: got %h expected 13", stm_page); end
        // Same offset address on a non-controller select must not touch the page.
        drive_write(2'd1, 14'h0020, 16'h0000, 2, 1'b0, n, w, f, a, d, o);
        checks++; if (w !== 4'b0010)  begin errors++; $display("FAIL sel1_we: got %b expected 0010", w); end
        checks++; if (mod_page !== 1'b1)  begin errors++; $display("FAIL sel1_mod: got %b expected 1", mod_page); end
        drive_write(2'd0, 14'h0022, 16'h0000, 2, 1'b0, n, w, f, a, d, o);
        checks++; if (stm_page !== 5'h13 || mod_page !== 1'b1) begin errors++; $display("FAIL adj_addr_pages: got %b/%h expected 1/13", mod_page, stm_page); end
    endtask

    task automatic test_long_hold();
        int n; logic [3:0] w; int f; logic [13:0] a; logic [15:0] d; logic o;
        drive_write(2'd2, 14'h0009, 16'hBEEF, 10, 1'b0, n, w, f, a, d, o);
        checks++; if (n !== 1) begin errors++; $display("FAIL long_hold_count: got %0d expected 1", n); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        logic [3:0]  last_we = 4'd0;
        logic [13:0] last_addr = 14'd0;
        logic [15:0] last_din = 16'd0;
        set_pins(1'b0, 1'b0, 1'b1, 2'd1, 14'h0010, 16'h1111);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bram_we != 4'd0) begin
                n++; last_we = bram_we; last_addr = bram_addr; last_din = bram_din;
            end
            if (i == 2) set_pins(1'b1, 1'b1, 1'b1, 2'd1, 14'h0010, 16'h1111);
            if (i == 3) set_pins(1'b0, 1'b0, 1'b1, 2'd3, 14'h0011, 16'h2222);
            if (i == 5) set_pins(1'b1, 1'b1, 1'b1, 2'd3, 14'h0011, 16'h2222);
        end
        checks++; if (n !== 2)             begin errors++; $display("FAIL b2b_count: got %0d expected 2", n); end
        checks++; if (last_we !== 4'b1000) begin errors++; $display("FAIL b2b_we: got %b expected 1000", last_we); end
        checks++; if (last_addr !== 14'h0011 || last_din !== 16'h2222) begin errors++; $display("FAIL b2b_data: got %h/%h expected 0011/2222", last_addr, last_din); end
    endtask

    task automatic test_read();
        logic        oe_h [1:10];
        logic [15:0] do_h [1:10];
        logic        any_oe = 1'b0;
        set_pins(1'b0, 1'b1, 1'b0, 2'd3, 14'h0100, 16'h0000);
        for (int i = 1; i <= 10; i++) begin
            tick();
            oe_h[i] = cpu_oe;
            do_h[i] = cpu_dout;
            if (cpu_oe) any_oe = 1'b1;
            if (i == 6) begin cs_n = 1'b1; rd_n = 1'b1; end
        end
`ifdef CPU_BUS_READBACK_EN
        checks++; if (oe_h[3] !== 1'b0)    begin errors++; $display("FAIL read_oe_early: got %b expected 0", oe_h[3]); end
        checks++; if (oe_h[4] !== 1'b1)    begin errors++; $display("FAIL read_oe_rise: got %b expected 1", oe_h[4]); end
        checks++; if (do_h[4] !== 16'h1234) begin errors++; $display("FAIL read_data: got %h expected 1234", do_h[4]); end
        checks++; if (oe_h[7] !== 1'b1)    begin errors++; $display("FAIL read_oe_hold: got %b expected 1", oe_h[7]); end
        checks++; if (oe_h[8] !== 1'b0)    begin errors++; $display("FAIL read_oe_drop: got %b expected 0", oe_h[8]); end
        checks++; if (do_h[8] !== 16'h1234) begin errors++; $display("FAIL read_data_keep: got %h expected 1234", do_h[8]); end
        checks++; if (rd_sel !== 2'd3 || bram_addr !== 14'h0100) begin errors++; $display("FAIL read_latch: got %h/%h expected 3/0100", rd_sel, bram_addr); end
`else
        checks++; if (any_oe !== 1'b0)     begin errors++; $display("FAIL read_disabled_oe: got %b expected 0", any_oe); end
        checks++; if (do_h[10] !== 16'h0000) begin errors++; $display("FAIL read_disabled_dout: got %h expected 0000", do_h[10]); end
        checks++; if (rd_sel !== 2'd0)     begin errors++; $display("FAIL read_disabled_sel: got %h expected 0", rd_sel); end
`endif
    endtask

    task automatic test_we_rd_together();
        int n; logic [3:0] w; int f; logic [13:0] a; logic [15:0] d; logic o;
        drive_write(2'd2, 14'h0007, 16'h7777, 2, 1'b1, n, w, f, a, d, o);
        checks++; if (n !== 1)       begin errors++; $display("FAIL werd_count: got %0d expected 1", n); end
        checks++; if (w !== 4'b0100) begin errors++; $display("FAIL werd_we: got %b expected 0100", w); end
        checks++; if (o !== 1'b0)    begin errors++; $display("FAIL werd_oe: got %b expected 0", o); end
    endtask

    task automatic test_abort();
        logic oe_seen = 1'b0;
        set_pins(1'b0, 1'b1, 1'b0, 2'd3, 14'h0100, 16'h0000);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (cpu_oe) oe_seen = 1'b1;
            if (i == 2) cs_n = 1'b1;
            if (i == 4) rd_n = 1'b1;
        end
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b expected 0", oe_seen); end
    endtask

    task automatic test_reset_wr_hold();
        int n_after = 0;
        int n; logic [3:0] w; int f; logic [13:0] a; logic [15:0] d; logic o;
        set_pins(1'b0, 1'b0, 1'b1, 2'd0, 14'h0005, 16'h0000);
        tick();
        tick();
        checks++; if (bram_we !== 4'b0001 || mod_page !== 1'b1) begin errors++; $display("FAIL rstwr_pre: got %b/%b expected 0001/1", bram_we, mod_page); end
        rst_n = 1'b0;
        #1;
        checks++; if (bram_we !== 4'd0)  begin errors++; $display("FAIL rstwr_we: got %b expected 0000", bram_we); end
        checks++; if (mod_page !== 1'b0) begin errors++; $display("FAIL rstwr_mod: got %b expected 0", mod_page); end
        checks++; if (stm_page !== 5'd0) begin errors++; $display("FAIL rstwr_stm: got %h expected 00", stm_page); end
        checks++; if (cpu_oe !== 1'b0)   begin errors++; $display("FAIL rstwr_oe: got %b expected 0", cpu_oe); end
        set_pins(1'b1, 1'b1, 1'b1, 2'd0, 14'h0005, 16'h0000);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (bram_we != 4'd0) n_after++;
        end
        checks++; if (n_after !== 0) begin errors++; $display("FAIL rstwr_no_strobe: got %0d expected 0", n_after); end
        drive_write(2'd2, 14'h0003, 16'h3333, 2, 1'b0, n, w, f, a, d, o);
        checks++; if (n !== 1 || w !== 4'b0100) begin errors++; $display("FAIL rstwr_fresh: got %0d/%b expected 1/0100", n, w); end
    endtask

    task automatic test_reset_rd_drive();
        set_pins(1'b0, 1'b1, 1'b0, 2'd3, 14'h0100, 16'h0000);
        for (int i = 1; i <= 5; i++) tick();
`ifdef CPU_BUS_READBACK_EN
        checks++; if (cpu_oe !== 1'b1) begin errors++; $display("FAIL rstrd_pre: got %b expected 1", cpu_oe); end
`endif
        rst_n = 1'b0;
        #1;
        checks++; if (cpu_oe !== 1'b0)     begin errors++; $display("FAIL rstrd_oe: got %b expected 0", cpu_oe); end
        checks++; if (cpu_dout !== 16'd0)  begin errors++; $display("FAIL rstrd_dout: got %h expected 0000", cpu_dout); end
        set_pins(1'b1, 1'b1, 1'b1, 2'd0, 14'h0000, 16'h0000);
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) tick();
        checks++; if (cpu_oe !== 1'b0 || bram_we !== 4'd0) begin errors++; $display("FAIL rstrd_after: got %b/%b expected 0/0000", cpu_oe, bram_we); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_page_regs();
        test_long_hold();
        test_back_to_back();
        test_read();
        test_we_rd_together();
        test_abort();
        test_reset_wr_hold();
        test_reset_rd_drive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
